ppu_vram_arbiter: RTL and testbench
===================================

// Module: ppu_vram_arbiter
// PURPOSE
//  Shares the PPU memory space (CHR, CIRAM nametables, palette RAM) between the background fetch FSM and the CPU
//  PPUDATA port. Renderer has fixed priority; CPU accesses are deferred to free slots. Also decodes PPU addresses
//  to the target memory, with nametable mirroring and palette mirroring. Sits between the rendering FSM / CPU
//  register file and the PPU-side block RAMs, in the 25 MHz clk domain.
// PARAMETERS
//  CPU_MAX_WAIT  16  CPU wait cycles (request to grant) above which stall_err is set
//  CHR_RAM       0   1: CPU writes to $0000-$1FFF reach CHR; 0: dropped (still acked)
// PORTS
//  clk          in   1   system clock, 25 MHz
//  rst          in   1   synchronous, active-high reset
//  mirror_v     in   1   1 = vertical nametable mirroring, 0 = horizontal
//  bg_rd        in   1   renderer read strobe, 1-cycle pulse, at most 1 per 2 clks
//  bg_addr      in   14  renderer PPU address, valid with bg_rd
//  bg_rvalid    out  1   1-cycle pulse: bg_rdata valid
//  bg_rdata     out  8   renderer read data, held until next bg_rvalid
//  cpu_req      in   1   CPU access request, level, held until cpu_ack
//  cpu_we       in   1   1 = write, 0 = read, sampled with cpu_req
//  cpu_addr     in   14  CPU PPU address
//  cpu_wdata    in   8   CPU write data
//  cpu_ack      out  1   1-cycle completion pulse
//  cpu_rdata    out  8   CPU read data, valid with cpu_ack on reads, held afterwards
//  mem_wdata    out  8   shared write data to all targets
//  chr_rd       out  1   CHR read enable; chr_we: out 1, CHR write enable
//  chr_addr     out  13  CHR address; chr_rdata: in 8
//  ciram_addr   out  11  nametable RAM address; ciram_we: out 1; ciram_rdata: in 8
//  pal_addr     out  5   palette RAM address; pal_we: out 1; pal_rdata: in 6, zero-extended to 8
//  stall_err    out  1   sticky: a CPU wait exceeded CPU_MAX_WAIT; cleared only by rst
// BEHAVIOUR
//  - Reset: all outputs 0, CPU FSM -> C_IDLE, pipeline valid bits cleared.
//  - Reset mid-access: in-flight accesses are dropped with no ack/rvalid; a pending cpu_req is re-sampled after rst.
//  - Issue stage, cycle N: bg_rd=1 issues the renderer access. Otherwise a CPU access in C_WAIT issues.
//    Bus outputs (addr/we/rd/mem_wdata) are registered and appear at N+1. Memories return data at N+2.
//  - bg_rvalid/bg_rdata: asserted at N+2 from the mux of the target recorded in the pipeline tag.
//  - CPU FSM states:
//      C_IDLE -> C_WAIT when cpu_req is sampled high.
//      C_WAIT -> C_ISSUE in the first cycle with bg_rd=0, latching we/addr/wdata.
//      C_ISSUE, write: cpu_ack at N+1, -> C_IDLE.
//      C_ISSUE, read: -> C_DATA; cpu_ack and cpu_rdata at N+2, -> C_IDLE.
//    cpu_req must stay low for at least 1 clk after ack before a new request is seen. No back-to-back self-reissue.
//  - Collision: bg_rd and an eligible CPU access in the same cycle -> renderer wins; CPU stays in C_WAIT.
//    The renderer is never delayed.
//  - Pipeline tag per stage {valid, owner, target[1:0]}: a CPU read in flight and a renderer read may overlap.
//    Each return is routed by its own tag.
//  - Wait counter: 5-bit saturating, counts C_WAIT cycles; > CPU_MAX_WAIT sets stall_err. Zeroed on entry to C_WAIT.
//  - Address decode, from a[13:0]:
//      a < $2000 -> CHR, chr_addr = a[12:0].
//      $2000-$3EFF -> CIRAM; ciram_addr = {mirror_v ? a[10] : a[11], a[9:0]}. $3000-$3EFF mirrors $2000-$2EFF.
//      $3F00-$3FFF -> palette; pal_addr = a[4:0], bit4 cleared when a[1:0]==0 ($3F10/14/18/1C -> $3F00/04/08/0C).
//  - Writes: CHR only if CHR_RAM=1, otherwise no strobe but acked; renderer never writes. Exactly one *_we/_rd per issued access.
// STRUCTURE
//  - Shared include ppu_defs.vh holds:
//      target codes TGT_CHR=0, TGT_CIRAM=1, TGT_PAL=2;
//      range constants PPU_NT_BASE=$2000, PPU_PAL_BASE=$3F00;
//      CPU FSM state encodings.
//  - One combinational sub-module ppu_addr_decode (a, mirror_v -> target, chr/ciram/pal addr).
//    It is instantiated twice, on the bg and cpu addresses.
// TESTING
//  - Vertical mirror: CPU write $2400=$5A, then read $2C00 -> $5A. Horizontal: write $2400, read $2000 -> same.
//  - Palette mirror: write $3F10=$21, read $3F00 -> $21, pal_addr=0. Read $3F11 -> independent entry, pal_addr=$11.
//  - Collision: cpu_req read $2000 and bg_rd $2001 same cycle -> bg issued first.
//    bg_rvalid 2 clks later; CPU issues next clk, cpu_ack 1 clk after bg_rvalid.
//  - bg_rd every 2nd clk for 40 clks with CPU pending -> CPU granted in 1st free slot, stall_err stays 0.
//    Forced bg_rd high 20 clks (illegal rate) -> stall_err=1.
//  - CHR_RAM=0: CPU write $0100 -> cpu_ack at N+1, chr_we never high. CPU read $0100 returns chr_rdata.
//  - rst asserted while CPU read is in C_DATA -> no cpu_ack, all outputs 0 next clk, FSM C_IDLE.

Source files
------------

// File: rtl/ppu_vram_arbiter_pkg.sv
// Shared types and constants for the PPU VRAM arbiter: target codes,
// PPU address map boundaries, CPU access FSM states and pipeline tags.
package ppu_vram_arbiter_pkg;

   typedef enum logic [1:0] {
      TGT_CHR   = 2'd0,
      TGT_CIRAM = 2'd1,
      TGT_PAL   = 2'd2
   } tgt_e;

   typedef enum logic [1:0] {
      C_IDLE,
      C_WAIT,
      C_ISSUE,
      C_DATA
   } cpu_state_e;

   typedef enum logic {
      OWN_BG  = 1'b0,
      OWN_CPU = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      tgt_e   target;
   } pipe_tag_t;

   localparam logic [13:0] PPU_NT_BASE  = 14'h2000;
   localparam logic [13:0] PPU_PAL_BASE = 14'h3F00;

   // Sprite-palette entry 0 of each group aliases the matching background entry.
   function automatic logic [4:0] pal_fold(input logic [4:0] a);
      return {a[4] & (a[1:0] != 2'b00), a[3:0]};
   endfunction

endpackage

// File: rtl/ppu_vram_arbiter_addr_decode.sv
// PPU address decoder: selects CHR / CIRAM / palette and forms the
// per-memory addresses, including nametable and palette mirroring.
module ppu_addr_decode
   import ppu_vram_arbiter_pkg::*;
(
   input  logic [13:0] a,
   input  logic        mirror_v,
   output logic [1:0]  target,
   output logic [12:0] chr_addr,
   output logic [10:0] ciram_addr,
   output logic [4:0]  pal_addr
);

   // Range decode and mirrored address formation.
   always_comb begin
      target = TGT_CIRAM;
      if (a < PPU_NT_BASE) begin
         target = TGT_CHR;
      end else if (a >= PPU_PAL_BASE) begin
         target = TGT_PAL;
      end
      chr_addr   = a[12:0];
      ciram_addr = {(mirror_v ? a[10] : a[11]), a[9:0]};
      pal_addr   = pal_fold(a[4:0]);
   end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// PPU memory arbiter: renderer reads have fixed priority, CPU PPUDATA
// accesses fill free slots. Registered bus, 2-cycle read return routed
// by a per-stage pipeline tag.
module ppu_vram_arbiter
   import ppu_vram_arbiter_pkg::*;
#(
   parameter int unsigned CPU_MAX_WAIT = 16,
   parameter int unsigned CHR_RAM      = 0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mirror_v,
   input  logic        bg_rd,
   input  logic [13:0] bg_addr,
   output logic        bg_rvalid,
   output logic [7:0]  bg_rdata,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [13:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic [7:0]  mem_wdata,
   output logic        chr_rd,
   output logic        chr_we,
   output logic [12:0] chr_addr,
   input  logic [7:0]  chr_rdata,
   output logic [10:0] ciram_addr,
   output logic        ciram_we,
   input  logic [7:0]  ciram_rdata,
   output logic [4:0]  pal_addr,
   output logic        pal_we,
   input  logic [5:0]  pal_rdata,
   output logic        stall_err
);

   cpu_state_e state, state_nxt;
   logic       cpu_we_q;
   logic [4:0] wait_cnt;
   pipe_tag_t  tag1, tag2;
   logic       issue_cpu;
   logic       bg_take, cpu_take;
   logic [7:0] rd_mux, bg_rdata_q, cpu_rdata_q;

   logic [1:0]  bg_tgt, cpu_tgt;
   logic [12:0] bg_chr_a, cpu_chr_a;
   logic [10:0] bg_ciram_a, cpu_ciram_a;
   logic [4:0]  bg_pal_a, cpu_pal_a;

   ppu_addr_decode u_dec_bg (
      .a          (bg_addr),
      .mirror_v   (mirror_v),
      .target     (bg_tgt),
      .chr_addr   (bg_chr_a),
      .ciram_addr (bg_ciram_a),
      .pal_addr   (bg_pal_a)
   );

   ppu_addr_decode u_dec_cpu (
      .a          (cpu_addr),
      .mirror_v   (mirror_v),
      .target     (cpu_tgt),
      .chr_addr   (cpu_chr_a),
      .ciram_addr (cpu_ciram_a),
      .pal_addr   (cpu_pal_a)
   );

   // CPU FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= C_IDLE;
      else     state <= state_nxt;
   end

   // CPU FSM next state; renderer strobe blocks the CPU issue slot.
   always_comb begin
      state_nxt = state;
      issue_cpu = 1'b0;
      case (state)
         C_IDLE:  if (cpu_req) state_nxt = C_WAIT;
         C_WAIT:  if (!bg_rd) begin
                     state_nxt = C_ISSUE;
                     issue_cpu = 1'b1;
                  end
         C_ISSUE: state_nxt = cpu_we_q ? C_IDLE : C_DATA;
         C_DATA:  state_nxt = C_IDLE;
         default: state_nxt = C_IDLE;
      endcase
   end

   // CPU direction latch, wait counter and sticky stall flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_we_q  <= 1'b0;
         wait_cnt  <= '0;
         stall_err <= 1'b0;
      end else begin
         if (state == C_IDLE && cpu_req) begin
            wait_cnt <= '0;
         end else if (state == C_WAIT && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 5'd1;
         end
         if (issue_cpu) cpu_we_q <= cpu_we;
         if (state == C_WAIT && 32'(wait_cnt) > CPU_MAX_WAIT) stall_err <= 1'b1;
      end
   end

   // Registered memory bus and pipeline tags; the bus registers double as
   // the CPU address/data latch, so only the direction is held separately.
   always_ff @(posedge clk) begin
      if (rst) begin
         chr_addr   <= '0;
         ciram_addr <= '0;
         pal_addr   <= '0;
         mem_wdata  <= '0;
         chr_rd     <= 1'b0;
         chr_we     <= 1'b0;
         ciram_we   <= 1'b0;
         pal_we     <= 1'b0;
         tag1       <= '0;
         tag2       <= '0;
      end else begin
         chr_rd   <= 1'b0;
         chr_we   <= 1'b0;
         ciram_we <= 1'b0;
         pal_we   <= 1'b0;
         tag1     <= '0;
         tag2     <= tag1;
         if (bg_rd) begin
            chr_addr   <= bg_chr_a;
            ciram_addr <= bg_ciram_a;
            pal_addr   <= bg_pal_a;
            chr_rd     <= (bg_tgt == TGT_CHR);
            tag1       <= '{valid: 1'b1, owner: OWN_BG, target: tgt_e'(bg_tgt)};
         end else if (issue_cpu) begin
            chr_addr   <= cpu_chr_a;
            ciram_addr <= cpu_ciram_a;
            pal_addr   <= cpu_pal_a;
            mem_wdata  <= cpu_wdata;
            tag1       <= '{valid: 1'b1, owner: OWN_CPU, target: tgt_e'(cpu_tgt)};
            if (cpu_we) begin
               case (tgt_e'(cpu_tgt))
                  TGT_CHR:   chr_we   <= (CHR_RAM != 0);
                  TGT_CIRAM: ciram_we <= 1'b1;
                  TGT_PAL:   pal_we   <= 1'b1;
                  default:   ;
               endcase
            end else begin
               chr_rd <= (cpu_tgt == TGT_CHR);
            end
         end
      end
   end

   // Return-data mux selected by the stage-2 tag.
   always_comb begin
      rd_mux = '0;
      case (tag2.target)
         TGT_CHR:   rd_mux = chr_rdata;
         TGT_CIRAM: rd_mux = ciram_rdata;
         TGT_PAL:   rd_mux = {2'b00, pal_rdata};
         default:   rd_mux = '0;
      endcase
   end

   // Completion strobes and read data; rst suppresses in-flight returns.
   always_comb begin
      bg_take   = !rst && tag2.valid && (tag2.owner == OWN_BG);
      cpu_take  = !rst && (state == C_DATA);
      bg_rvalid = bg_take;
      bg_rdata  = bg_take ? rd_mux : bg_rdata_q;
      cpu_ack   = !rst && ((state == C_ISSUE && cpu_we_q) || state == C_DATA);
      cpu_rdata = cpu_take ? rd_mux : cpu_rdata_q;
   end

   // Hold registers so read data stays stable between completions.
   always_ff @(posedge clk) begin
      if (rst) begin
         bg_rdata_q  <= '0;
         cpu_rdata_q <= '0;
      end else begin
         if (bg_take)  bg_rdata_q  <= rd_mux;
         if (cpu_take) cpu_rdata_q <= rd_mux;
      end
   end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter with behavioural CHR/CIRAM/palette memories.
module tb_ppu_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mirror_v = 1'b0;
   logic        bg_rd = 1'b0;
   logic [13:0] bg_addr = '0;
   logic        bg_rvalid;
   logic [7:0]  bg_rdata;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [13:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [7:0]  mem_wdata;
   logic        chr_rd, chr_we;
   logic [12:0] chr_addr;
   logic [7:0]  chr_rdata = '0;
   logic [10:0] ciram_addr;
   logic        ciram_we;
   logic [7:0]  ciram_rdata = '0;
   logic [4:0]  pal_addr;
   logic        pal_we;
   logic [5:0]  pal_rdata = '0;
   logic        stall_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] ciram_mem [2048];
   logic [5:0] pal_mem [32];
   logic       chr_we_seen = 1'b0;

   ppu_vram_arbiter #(.CPU_MAX_WAIT(16), .CHR_RAM(0)) dut (
      .clk(clk), .rst(rst), .mirror_v(mirror_v),
      .bg_rd(bg_rd), .bg_addr(bg_addr), .bg_rvalid(bg_rvalid), .bg_rdata(bg_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_wdata(mem_wdata),
      .chr_rd(chr_rd), .chr_we(chr_we), .chr_addr(chr_addr), .chr_rdata(chr_rdata),
      .ciram_addr(ciram_addr), .ciram_we(ciram_we), .ciram_rdata(ciram_rdata),
      .pal_addr(pal_addr), .pal_we(pal_we), .pal_rdata(pal_rdata),
      .stall_err(stall_err)
   );

   always #5 clk = ~clk;

   // Synchronous-read memories; CHR is read-only with address-derived contents.
   always @(posedge clk) begin
      chr_rdata <= chr_addr[7:0] ^ {3'b000, chr_addr[12:8]} ^ 8'hA5;
      if (rst) begin
         for (int i = 0; i < 2048; i++) ciram_mem[i] <= 8'(i) ^ 8'h3C;
         for (int i = 0; i < 32; i++) pal_mem[i] <= 6'(i);
      end else begin
         if (ciram_we) ciram_mem[ciram_addr] <= mem_wdata;
         if (pal_we) pal_mem[pal_addr] <= mem_wdata[5:0];
      end
      ciram_rdata <= ciram_mem[ciram_addr];
      pal_rdata   <= pal_mem[pal_addr];
      if (chr_we === 1'b1) chr_we_seen <= 1'b1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CPU transaction; lat counts clocks from request to the ack cycle.
   task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] wd,
                             output logic [7:0] rd, output int lat);
      logic done;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      rd = '0; lat = 0; done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
         cyc();
         lat++;
         if (cpu_ack === 1'b1) begin
            rd = cpu_rdata;
            done = 1'b1;
         end
      end
      cpu_req = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rd;
      int lat;

      // Reset state
      repeat (3) cyc();
      check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      check("rst_bg_rvalid", 32'(bg_rvalid), 32'd0);
      check("rst_stall", 32'(stall_err), 32'd0);
      check("rst_strobes", 32'({chr_rd, chr_we, ciram_we, pal_we}), 32'd0);
      check("rst_addrs", 32'({chr_addr, ciram_addr, pal_addr}), 32'd0);
      check("rst_data", 32'({cpu_rdata, bg_rdata, mem_wdata}), 32'd0);
      rst = 1'b0;
      cyc();

      // CHR write dropped but acked one clock after issue; read returns CHR data
      cpu_access(1'b1, 14'h0100, 8'h77, rd, lat);
      check("chr_wr_lat", 32'(lat), 32'd2);
      check("chr_wr_wdata", 32'(mem_wdata), 32'h77);
      cpu_access(1'b0, 14'h0100, 8'h00, rd, lat);
      check("chr_rd_lat", 32'(lat), 32'd3);
      check("chr_rd_data", 32'(rd), 32'hA4);
      check("chr_rd_hold", 32'(cpu_rdata), 32'hA4);
      check("chr_rd_addr", 32'(chr_addr), 32'h100);
      check("chr_we_never", 32'(chr_we_seen), 32'd0);

      // Vertical mirroring
      mirror_v = 1'b1;
      cpu_access(1'b1, 14'h2400, 8'h5A, rd, lat);
      check("vmir_wr_addr", 32'(ciram_addr), 32'h400);
      cpu_access(1'b0, 14'h2C00, 8'h00, rd, lat);
      check("vmir_rd", 32'(rd), 32'h5A);

      // Horizontal mirroring
      mirror_v = 1'b0;
      cpu_access(1'b1, 14'h2400, 8'hA5, rd, lat);
      check("hmir_wr_addr", 32'(ciram_addr), 32'h000);
      cpu_access(1'b0, 14'h2000, 8'h00, rd, lat);
      check("hmir_rd_2000", 32'(rd), 32'hA5);
      cpu_access(1'b0, 14'h2800, 8'h00, rd, lat);
      check("hmir_rd_2800", 32'(rd), 32'h5A);
      cpu_access(1'b0, 14'h3EFF, 8'h00, rd, lat);
      check("nt_top_rd", 32'(rd), 32'hC3);
      check("nt_top_addr", 32'(ciram_addr), 32'h6FF);

      // Palette mirroring and 6-bit storage
      cpu_access(1'b1, 14'h3F10, 8'h21, rd, lat);
      check("pal_wr_addr", 32'(pal_addr), 32'h00);
      cpu_access(1'b0, 14'h3F00, 8'h00, rd, lat);
      check("pal_rd_3f00", 32'(rd), 32'h21);
      cpu_access(1'b0, 14'h3F11, 8'h00, rd, lat);
      check("pal_rd_3f11", 32'(rd), 32'h11);
      check("pal_rd_addr", 32'(pal_addr), 32'h11);
      cpu_access(1'b1, 14'h3F05, 8'hFF, rd, lat);
      cpu_access(1'b0, 14'h3F05, 8'h00, rd, lat);
      check("pal_zext", 32'(rd), 32'h3F);

      // Collision: renderer wins, CPU read issues the next clock
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
      bg_rd = 1'b1; bg_addr = 14'h2001;
      cyc();
      bg_rd = 1'b0;
      check("col_bus_bg", 32'(ciram_addr), 32'h001);
      check("col_t1_rvalid", 32'(bg_rvalid), 32'd0);
      check("col_t1_ack", 32'(cpu_ack), 32'd0);
      cyc();
      check("col_t2_rvalid", 32'(bg_rvalid), 32'd1);
      check("col_t2_rdata", 32'(bg_rdata), 32'h3D);
      check("col_bus_cpu", 32'(ciram_addr), 32'h000);
      check("col_t2_ack", 32'(cpu_ack), 32'd0);
      cyc();
      check("col_t3_ack", 32'(cpu_ack), 32'd1);
      check("col_t3_rdata", 32'(cpu_rdata), 32'hA5);
      check("col_t3_rvalid", 32'(bg_rvalid), 32'd0);
      check("col_bg_hold", 32'(bg_rdata), 32'h3D);
      cpu_req = 1'b0;
      cyc();

      // Renderer every 2nd clock with a CPU read pending
      for (int i = 0; i < 40; i++) begin
         check("sp_rvalid", 32'(bg_rvalid), 32'((i >= 2) && (i % 2 == 0)));
         if (bg_rvalid === 1'b1) check("sp_rdata", 32'(bg_rdata), 32'(8'(i - 2) ^ 8'hA5));
         check("sp_ack", 32'(cpu_ack), 32'(i == 5));
         if (i == 5) check("sp_cpu_rdata", 32'(cpu_rdata), 32'h3D);
         bg_rd = (i % 2 == 0);
         bg_addr = 14'(i);
         cpu_req = (i >= 1) && (i <= 4);
         cpu_we = 1'b0;
         cpu_addr = 14'h2001;
         cyc();
      end
      bg_rd = 1'b0;
      check("sp_no_stall", 32'(stall_err), 32'd0);
      cyc(); cyc();

      // Renderer held high for 20 clocks starves the CPU past the limit
      for (int i = 0; i < 25; i++) begin
         if (i == 10) check("st_not_yet", 32'(stall_err), 32'd0);
         if (i == 21) check("st_set", 32'(stall_err), 32'd1);
         if (i == 21) check("st_cpu_strobe", 32'(chr_rd), 32'd1);
         if (i == 23) check("st_strobe_off", 32'(chr_rd), 32'd0);
         check("st_ack", 32'(cpu_ack), 32'(i == 22));
         if (i == 22) check("st_rdata", 32'(cpu_rdata), 32'hA4);
         bg_rd = (i < 20);
         bg_addr = 14'h0010;
         cpu_req = (i < 22);
         cpu_we = 1'b0;
         cpu_addr = 14'h0100;
         cyc();
      end
      check("st_sticky", 32'(stall_err), 32'd1);

      // Reset while the CPU read is in its data cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0100;
      cyc(); cyc(); cyc();
      rst = 1'b1;
      #1;
      check("rr_no_ack", 32'(cpu_ack), 32'd0);
      cyc();
      check("rr_ack", 32'(cpu_ack), 32'd0);
      check("rr_rdata", 32'({cpu_rdata, bg_rdata, mem_wdata}), 32'd0);
      check("rr_stall", 32'(stall_err), 32'd0);
      check("rr_bus", 32'({chr_rd, chr_we, ciram_we, pal_we, chr_addr, ciram_addr, pal_addr}), 32'd0);
      rst = 1'b0;
      cpu_access(1'b0, 14'h0100, 8'h00, rd, lat);
      check("rr_resample_lat", 32'(lat), 32'd3);
      check("rr_resample_data", 32'(rd), 32'hA4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
